// File: rtl/conv2x2_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv2x2_window_gen.
// Both sides are valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface conv2x2_window_gen_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        sof;
  logic [31:0] win_out;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;
  logic        frame_done;

  modport master (
    output pix_in, pix_valid, sof, win_ready,
    input  pix_ready, win_out, win_valid, win_last, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof, win_ready,
    output pix_ready, win_out, win_valid, win_last, frame_done
  );
endinterface

// File: rtl/conv2x2_window_gen.sv
// Raster-scan pixel stream to stride-1 2x2 windows, one packed 32-bit word per window.
// Byte order: [7:0]=top-left, [15:8]=top-right, [23:16]=bottom-left, [31:24]=bottom-right.
module conv2x2_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv2x2_window_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic [31:0]   win_out_q, win_out_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic          frame_done_q, frame_done_d;

  // Line buffer holds the previous row; left_q is the last accepted pixel and
  // above_left_q is the line-buffer entry that pixel overwrote.
  logic [7:0]    line_q [IMG_W];
  logic [7:0]    left_q;
  logic [7:0]    above_left_q;

  logic          accept;
  logic          win_load;
  logic          at_row_end;
  logic          at_frame_end;

  assign bus.pix_ready  = !win_valid_q || bus.win_ready;
  assign accept         = bus.pix_valid && bus.pix_ready;

  // sof forces the accepted pixel to (0,0) regardless of the counters.
  assign col_eff        = bus.sof ? '0 : col_q;
  assign row_eff        = bus.sof ? '0 : row_q;
  assign at_row_end     = (col_eff == COL_LAST);
  assign at_frame_end   = at_row_end && (row_eff == ROW_LAST);
  assign win_load       = accept && (row_eff != '0) && (col_eff != '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (at_row_end) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_comb begin
    win_out_d    = win_out_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    frame_done_d = accept && at_frame_end;
    if (win_load) begin
      win_out_d   = {bus.pix_in, left_q, line_q[col_eff], above_left_q};
      win_valid_d = 1'b1;
      win_last_d  = at_frame_end;
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel storage needs no reset: every entry is rewritten by row 0 before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[col_eff] <= bus.pix_in;
      left_q          <= bus.pix_in;
      above_left_q    <= line_q[col_eff];
    end
  end

  assign bus.win_out    = win_out_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_last   = win_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2x2_window_gen.sv
// Directed bench for conv2x2_window_gen: a 4x3 instance for most scenarios and a 2x2 instance
// for the minimum-size frame. Windows are scored against a queue of {win_last, win_out}.
module tb_conv2x2_window_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       sof;
  logic       win_ready;
  logic       pv_a;
  logic       pv_b;

  always #5 clk = ~clk;

  conv2x2_window_gen_if if_a ();
  conv2x2_window_gen_if if_b ();

  assign if_a.pix_in    = pix_in;
  assign if_a.pix_valid = pv_a;
  assign if_a.sof       = sof;
  assign if_a.win_ready = win_ready;
  assign if_b.pix_in    = pix_in;
  assign if_b.pix_valid = pv_b;
  assign if_b.sof       = sof;
  assign if_b.win_ready = win_ready;

  conv2x2_window_gen #(.IMG_W(4), .IMG_H(3)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  conv2x2_window_gen #(.IMG_W(2), .IMG_H(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_cmp = 0;
  int n_err = 0;
  int fd_a  = 0;
  int fd_b  = 0;
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a consume happens at the next posedge when valid && ready at negedge.
  always @(negedge clk) begin
    if (!rst && if_a.win_valid && win_ready) begin
      if (exp_a.size() == 0) check("win_a_unexpected", 33'(exp_a.size()), 33'd1);
      else check("win_a", {if_a.win_last, if_a.win_out}, exp_a.pop_front());
    end
    if (!rst && if_b.win_valid && win_ready) begin
      if (exp_b.size() == 0) check("win_b_unexpected", 33'(exp_b.size()), 33'd1);
      else check("win_b", {if_b.win_last, if_b.win_out}, exp_b.pop_front());
    end
    if (!rst && if_a.frame_done) fd_a++;
    if (!rst && if_b.frame_done) fd_b++;
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the pixel.
  task automatic push(input bit sel, input logic [7:0] p, input logic s, input int max_gap);
    int gap;
    bit acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    acc = 1'b0;
    repeat (gap) begin
      pv_a = 1'b0;
      pv_b = 1'b0;
      pix_in = 8'hEE;
      @(posedge clk); #1;
    end
    pix_in = p;
    sof    = s;
    if (sel) pv_b = 1'b1; else pv_a = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = sel ? if_b.pix_ready : if_a.pix_ready;
      @(posedge clk); #1;
    end
    pv_a = 1'b0;
    pv_b = 1'b0;
    sof  = 1'b0;
    if (!acc) check("push_timeout", 33'(acc), 33'd1);
  endtask

  task automatic push_seq(input bit sel, input logic [7:0] base, input int n,
                          input bit sof_first, input int max_gap);
    for (int i = 0; i < n; i++) push(sel, base + 8'(i), sof_first && (i == 0), max_gap);
  endtask

  task automatic load_basic();
    exp_a.push_back({1'b0, 32'h05040100});
    exp_a.push_back({1'b0, 32'h06050201});
    exp_a.push_back({1'b0, 32'h07060302});
    exp_a.push_back({1'b0, 32'h09080504});
    exp_a.push_back({1'b0, 32'h0A090605});
    exp_a.push_back({1'b1, 32'h0B0A0706});
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold_after_first();
    int k;
    k = 0;
    while (!if_a.win_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_wait_first", 33'(k < 100), 33'd1);
    win_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_win", {if_a.win_last, if_a.win_out}, {1'b0, 32'h05040100});
      check("bp_hold_valid", 33'(if_a.win_valid), 33'd1);
      check("bp_pix_ready", 33'(if_a.pix_ready), 33'd0);
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_in = 8'h00; sof = 1'b0; win_ready = 1'b1; pv_a = 1'b0; pv_b = 1'b0;
    #12;
    check("rst_win_valid", 33'(if_a.win_valid), 33'd0);
    check("rst_win_out", 33'(if_a.win_out), 33'd0);
    check("rst_win_last", 33'(if_a.win_last), 33'd0);
    check("rst_frame_done", 33'(if_a.frame_done), 33'd0);
    check("rst_pix_ready", 33'(if_a.pix_ready), 33'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame with continuous ready.
    load_basic();
    push_seq(1'b0, 8'h00, 12, 1'b1, 0);
    check("basic_fd_pulse", 33'(if_a.frame_done), 33'd1);
    idle(1);
    check("basic_fd_clear", 33'(if_a.frame_done), 33'd0);
    idle(3);
    check("basic_drain", 33'(exp_a.size()), 33'd0);
    check("basic_fd_count", 33'(fd_a), 33'd1);

    // Backpressure for 5 cycles after the first window.
    load_basic();
    fork
      push_seq(1'b0, 8'h00, 12, 1'b1, 0);
      hold_after_first();
    join
    idle(4);
    check("bp_drain", 33'(exp_a.size()), 33'd0);
    check("bp_fd_count", 33'(fd_a), 33'd2);

    // Random bubbles on pix_valid.
    load_basic();
    push_seq(1'b0, 8'h00, 12, 1'b1, 3);
    idle(4);
    check("bub_drain", 33'(exp_a.size()), 33'd0);
    check("bub_fd_count", 33'(fd_a), 33'd3);

    // sof on the 6th pixel restarts the frame with no window for that pixel.
    push_seq(1'b0, 8'h00, 5, 1'b1, 0);
    push(1'b0, 8'h50, 1'b1, 0);
    check("sof_no_win", 33'(if_a.win_valid), 33'd0);
    push_seq(1'b0, 8'h51, 4, 1'b0, 0);
    check("sof_no_win_row0", 33'(if_a.win_valid), 33'd0);
    exp_a.push_back({1'b0, 32'h55545150});
    exp_a.push_back({1'b0, 32'h56555251});
    exp_a.push_back({1'b0, 32'h57565352});
    exp_a.push_back({1'b0, 32'h59585554});
    exp_a.push_back({1'b0, 32'h5A595655});
    exp_a.push_back({1'b1, 32'h5B5A5756});
    push(1'b0, 8'h55, 1'b0, 0);
    check("sof_first_win", {if_a.win_last, if_a.win_out}, {1'b0, 32'h55545150});
    push_seq(1'b0, 8'h56, 6, 1'b0, 0);
    idle(4);
    check("sof_drain", 33'(exp_a.size()), 33'd0);
    check("sof_fd_count", 33'(fd_a), 33'd4);

    // Asynchronous reset between edges while a window is held.
    win_ready = 1'b0;
    push_seq(1'b0, 8'h00, 6, 1'b1, 0);
    check("arst_pre_valid", 33'(if_a.win_valid), 33'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_win_valid", 33'(if_a.win_valid), 33'd0);
    check("arst_win_out", 33'(if_a.win_out), 33'd0);
    check("arst_frame_done", 33'(if_a.frame_done), 33'd0);
    check("arst_pix_ready", 33'(if_a.pix_ready), 33'd1);
    #3;
    rst = 1'b0;
    win_ready = 1'b1;
    @(posedge clk); #1;
    load_basic();
    push_seq(1'b0, 8'h00, 12, 1'b1, 0);
    check("arst_fd_pulse", 33'(if_a.frame_done), 33'd1);
    idle(4);
    check("arst_drain", 33'(exp_a.size()), 33'd0);
    check("arst_fd_count", 33'(fd_a), 33'd5);

    // Minimum 2x2 frame on the second instance.
    exp_b.push_back({1'b1, 32'h44332211});
    push(1'b1, 8'h11, 1'b1, 0);
    push(1'b1, 8'h22, 1'b0, 0);
    push(1'b1, 8'h33, 1'b0, 0);
    push(1'b1, 8'h44, 1'b0, 0);
    check("min_win", {if_b.win_last, if_b.win_out}, {1'b1, 32'h44332211});
    check("min_fd_pulse", 33'(if_b.frame_done), 33'd1);
    idle(4);
    check("min_drain", 33'(exp_b.size()), 33'd0);
    check("min_fd_count", 33'(fd_b), 33'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
